// File: rtl/ren_conv_wb_master.sv
// Wishbone classic initiator: turns one command into an incrementing-address burst.
// Optional STB/ACK timeout abort is built when REN_WBM_TIMEOUT_EN is defined.
module ren_conv_wb_master #(
    parameter int unsigned LEN_WIDTH      = 8,
    parameter int unsigned ADDR_STEP      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [31:0]          cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [31:0]          wr_data,
    output logic                 rd_valid,
    output logic [31:0]          rd_data,
    output logic                 done,
    output logic                 err,
    output logic                 busy,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    input  logic                 wbm_ack_i,
    input  logic [31:0]          wbm_dat_i
);

    typedef enum logic [1:0] {IDLE, WDAT, STB, GAP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_WIDTH:0] beats;
    logic               last_beat;
    logic               timeout_hit;

    assign last_beat = (beats == (LEN_WIDTH + 1)'(1));
    assign wbm_sel_o = 4'hF;

`ifdef REN_WBM_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] tcnt;

    // Counter holds the number of ACK-less STB cycles already elapsed.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state != STB)
            tcnt <= '0;
        else if (!wbm_ack_i)
            tcnt <= tcnt + TW'(1);
    end

    assign timeout_hit = (state == STB) && !wbm_ack_i && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_valid) state_nxt = cmd_we ? WDAT : STB;
            WDAT: if (wr_valid) state_nxt = STB;
            STB: begin
                if (wbm_ack_i)
                    state_nxt = last_beat ? IDLE : GAP;
                else if (timeout_hit)
                    state_nxt = IDLE;
            end
            GAP:  state_nxt = wbm_we_o ? WDAT : STB;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        wbm_cyc_o = (state != IDLE);
        wbm_stb_o = (state == STB);
        wr_ready  = (state == WDAT) && wr_valid;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            beats     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_addr & 32'hFFFF_FFFC;
                        beats     <= {1'b0, cmd_len} + (LEN_WIDTH + 1)'(1);
                    end
                end
                WDAT: begin
                    if (wr_valid)
                        wbm_dat_o <= wr_data;
                end
                STB: begin
                    if (wbm_ack_i) begin
                        if (!wbm_we_o) begin
                            rd_data  <= wbm_dat_i;
                            rd_valid <= 1'b1;
                        end
                        beats     <= beats - (LEN_WIDTH + 1)'(1);
                        wbm_adr_o <= wbm_adr_o + 32'(ADDR_STEP);
                        done      <= last_beat;
                    end else if (timeout_hit) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ren_conv_wb_master.sv
// Self-checking bench for ren_conv_wb_master with a one-cycle registered-ACK slave model.
// Expected bus beats and read words are queued when a command is issued and popped as the DUT produces them.
module tb_ren_conv_wb_master;

    localparam int LW = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } beat_t;

    logic          clk = 1'b0;
    logic          wb_rst_i;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [31:0]   cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [31:0]   wr_data;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic          done, err, busy;
    logic          cyc, stb, we_o;
    logic [3:0]    sel;
    logic [31:0]   adr, dat_o;
    logic          ack;
    logic [31:0]   dat_i;

    logic          slave_en = 1'b1;
    logic [31:0]   rd_base  = '0;

    beat_t         exp_bus[$];
    logic [31:0]   exp_rd[$];
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    ren_conv_wb_master #(
        .LEN_WIDTH(LW),
        .ADDR_STEP(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_we_o (we_o),
        .wbm_sel_o(sel),
        .wbm_adr_o(adr),
        .wbm_dat_o(dat_o),
        .wbm_ack_i(ack),
        .wbm_dat_i(dat_i)
    );

    // Registered-ACK slave: acknowledges one cycle after STB is seen, read data derived from address.
    always @(posedge clk) begin
        if (wb_rst_i)
            ack <= 1'b0;
        else if (ack)
            ack <= 1'b0;
        else if (cyc && stb && slave_en) begin
            ack   <= 1'b1;
            dat_i <= rd_base ^ adr;
        end
    end

    // Issues one command and watches the burst to completion against the queued expectations.
    task automatic drive_and_watch(input string name, input logic we, input logic [31:0] addr,
                                   input int unsigned len, input logic [31:0] wbase,
                                   input int stall_beat, input int unsigned stall_n);
        int unsigned beats     = len + 1;
        int unsigned exp_done  = (we ? 4 : 3) * beats + ((stall_beat >= 0) ? stall_n : 0);
        int unsigned idx       = 0;
        int unsigned held      = 0;
        int unsigned wr_pulses = 0;
        int unsigned done_cyc  = 0;
        logic        consumed  = 1'b0;
        logic        prev_ack  = 1'b0;
        logic        cyc_drop  = 1'b0;
        beat_t       b;
        logic [31:0] r;
        for (int unsigned i = 0; i < beats; i++) begin
            b.we  = we;
            b.adr = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
            b.dat = we ? wbase + 32'(i) : '0;
            exp_bus.push_back(b);
            if (!we) exp_rd.push_back(rd_base ^ b.adr);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s cmd_ready_before: got %b want 1", name, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = LW'(len);
        for (int unsigned c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) cmd_valid = 1'b0;
            if (consumed) idx++;
            wr_data  = wbase + 32'(idx);
            wr_valid = we && (idx < beats) && !(int'(idx) == stall_beat && held < stall_n);
            #1;
            consumed = wr_ready;
            if (wr_ready) wr_pulses++;
            if (cyc && !stb && !prev_ack && !wr_valid && we && int'(idx) == stall_beat) held++;
            if (stb) begin
                checks++;
                if (exp_bus.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_stb: adr %h", name, adr);
                end else begin
                    b = exp_bus[0];
                    if (adr !== b.adr || we_o !== b.we || (b.we && dat_o !== b.dat) || sel !== 4'hF) begin
                        failures++;
                        $display("FAIL %s beat: got adr=%h we=%b dat=%h sel=%h want adr=%h we=%b dat=%h sel=f",
                                 name, adr, we_o, dat_o, sel, b.adr, b.we, b.dat);
                    end
                    if (ack) void'(exp_bus.pop_front());
                end
            end
            if (rd_valid) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_rd_valid: data %h", name, rd_data);
                end else begin
                    r = exp_rd.pop_front();
                    if (rd_data !== r) begin
                        failures++;
                        $display("FAIL %s rd_data: got %h want %h", name, rd_data, r);
                    end
                end
            end
            if (prev_ack && !done) begin
                checks++;
                if (stb !== 1'b0 || cyc !== 1'b1) begin
                    failures++;
                    $display("FAIL %s gap: got cyc=%b stb=%b want cyc=1 stb=0", name, cyc, stb);
                end
            end
            if (done) begin
                done_cyc = c;
                checks++;
                if (cyc !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done_cycle_state: got cyc=%b err=%b cmd_ready=%b busy=%b want 0 0 1 0",
                             name, cyc, err, cmd_ready, busy);
                end
                break;
            end
            if (cyc !== 1'b1) cyc_drop = 1'b1;
            prev_ack = stb && ack;
        end
        wr_valid = 1'b0;
        checks++;
        if (done_cyc != exp_done) begin
            failures++;
            $display("FAIL %s done_latency: got %0d want %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (exp_bus.size() != 0 || exp_rd.size() != 0) begin
            failures++;
            $display("FAIL %s leftover: got beats=%0d reads=%0d want 0 0", name, exp_bus.size(), exp_rd.size());
        end
        checks++;
        if (wr_pulses != (we ? beats : 0)) begin
            failures++;
            $display("FAIL %s wr_ready_pulses: got %0d want %0d", name, wr_pulses, we ? beats : 0);
        end
        checks++;
        if (cyc_drop) begin
            failures++;
            $display("FAIL %s cyc_continuous: got drop want none", name);
        end
        exp_bus.delete();
        exp_rd.delete();
    endtask

    task automatic test_reset();
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        wr_valid  = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || cyc !== 1'b0 || stb !== 1'b0 || we_o !== 1'b0 ||
            sel !== 4'hF || adr !== '0 || dat_o !== '0 || rd_valid !== 1'b0 || rd_data !== '0 ||
            done !== 1'b0 || err !== 1'b0 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got rdy=%b busy=%b cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rv=%b rd=%h done=%b err=%b wrr=%b",
                     cmd_ready, busy, cyc, stb, we_o, sel, adr, dat_o, rd_valid, rd_data, done, err, wr_ready);
        end
        wb_rst_i = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (wr_ready !== 1'b0 || cmd_ready !== 1'b1 || cyc !== 1'b0) begin
            failures++;
            $display("FAIL idle_wr_valid_ignored: got wr_ready=%b cmd_ready=%b cyc=%b want 0 1 0", wr_ready, cmd_ready, cyc);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_single_read();
        rd_base = 32'hDEAD_BEEF ^ 32'h3000_0010;
        drive_and_watch("single_read", 1'b0, 32'h3000_0010, 0, '0, -1, 0);
    endtask

    task automatic test_write_burst();
        drive_and_watch("write_burst", 1'b1, 32'h3100_0000, 3, 32'd1, -1, 0);
    endtask

    task automatic test_write_stall();
        drive_and_watch("write_stall", 1'b1, 32'h3100_0100, 3, 32'h0000_0100, 1, 5);
    endtask

    task automatic test_addr_wrap();
        rd_base = 32'h1234_5678;
        drive_and_watch("addr_wrap", 1'b0, 32'hFFFF_FFFC, 1, '0, -1, 0);
        drive_and_watch("addr_align", 1'b0, 32'h3200_0003, 0, '0, -1, 0);
    endtask

    task automatic test_back_to_back();
        rd_base = 32'h0F0F_5555;
        drive_and_watch("b2b_read", 1'b0, 32'h3300_0040, 2, '0, -1, 0);
        drive_and_watch("b2b_write", 1'b1, 32'h3300_0080, 0, 32'hCAFE_0000, -1, 0);
        drive_and_watch("b2b_read2", 1'b0, 32'h3300_00C0, 0, '0, -1, 0);
    endtask

    task automatic test_reset_mid_burst();
        int unsigned acks  = 0;
        logic        found = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 32'h3400_0000;
        cmd_len   = LW'(3);
        for (int unsigned c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) cmd_valid = 1'b0;
            wr_valid = 1'b1;
            wr_data  = 32'hAB00_0000 + 32'(c);
            #1;
            if (stb && ack) acks++;
            if (acks == 1 && stb && !ack) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rst_mid_reach_beat2: got not reached want reached");
        end
        wb_rst_i = 1'b1;
        @(posedge clk);
        #1;
        wb_rst_i = 1'b0;
        wr_valid = 1'b0;
        #1;
        checks++;
        if (cyc !== 1'b0 || stb !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_burst: got cyc=%b stb=%b done=%b err=%b rdy=%b busy=%b want 0 0 0 0 1 0",
                     cyc, stb, done, err, cmd_ready, busy);
        end
        @(posedge clk);
        #2;
        checks++;
        if (done !== 1'b0 || cyc !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_after: got done=%b cyc=%b want 0 0", done, cyc);
        end
        drive_and_watch("after_reset_write", 1'b1, 32'h3400_0100, 1, 32'h0000_0077, -1, 0);
    endtask

    task automatic test_timeout();
        int unsigned stb_cnt = 0;
        logic        seen    = 1'b0;
        slave_en  = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h3500_0000;
        cmd_len   = LW'(2);
`ifdef REN_WBM_TIMEOUT_EN
        for (int unsigned c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) cmd_valid = 1'b0;
            #1;
            if (stb) stb_cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || err !== 1'b1 || cyc !== 1'b0 || stb !== 1'b0 || stb_cnt != 16 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_abort: got done=%b err=%b cyc=%b stb=%b stb_cycles=%0d want 1 1 0 0 16",
                     seen, err, cyc, stb, stb_cnt);
        end
        @(posedge clk);
        #2;
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: got done=%b err=%b want 0 0", done, err);
        end
`else
        for (int unsigned c = 1; c <= 1000; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) cmd_valid = 1'b0;
            #1;
            if (stb) stb_cnt++;
            if (done || err) seen = 1'b1;
        end
        checks++;
        if (seen || stb !== 1'b1 || cyc !== 1'b1 || stb_cnt != 1000) begin
            failures++;
            $display("FAIL no_timeout_wait: got done_or_err=%b stb=%b cyc=%b stb_cycles=%0d want 0 1 1 1000",
                     seen, stb, cyc, stb_cnt);
        end
        wb_rst_i = 1'b1;
        @(posedge clk);
        #1;
        wb_rst_i = 1'b0;
        #1;
        checks++;
        if (cyc !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL no_timeout_recover: got cyc=%b cmd_ready=%b want 0 1", cyc, cmd_ready);
        end
`endif
        slave_en = 1'b1;
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        test_reset();
        test_single_read();
        test_write_burst();
        test_write_stall();
        test_addr_wrap();
        test_back_to_back();
        test_reset_mid_burst();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
